// File: rtl/conv_window_gen.sv
// Sliding KxK window generator for raster pixel streams (valid conv, stride 1, or 2 with CONV_WINDOW_STRIDE2_EN).
// Latency: 1 cycle from accepting the bottom-right pixel to out_valid.
// Backpressure: none; a pixel is consumed on every in_valid cycle.
module conv_window_gen #(
  parameter int WORDWIDTH = 32,
  parameter int KSIZE     = 5,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [WORDWIDTH-1:0]               in_pix,
  input  logic                               in_valid,
  input  logic                               in_sof,
  output logic [WORDWIDTH*KSIZE*KSIZE-1:0]   win,
  output logic                               out_valid,
  output logic                               frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NB = KSIZE - 1;
  localparam logic [CW-1:0] C_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_FIRST = CW'(KSIZE - 1);
  localparam logic [RW-1:0] R_FIRST = RW'(KSIZE - 1);

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_ptr;
  logic [CW-1:0]        w_col;
  logic [RW-1:0]        w_row;
  logic [WORDWIDTH-1:0] r_lb [NB][IMG_W];
  logic [WORDWIDTH-1:0] w_lb_out [NB];
  logic [WORDWIDTH-1:0] w_newcol [KSIZE];
  logic [KSIZE*KSIZE-1:0][WORDWIDTH-1:0] r_win;
  logic                 w_win_ok;
  logic                 w_last_pix;
  logic                 r_out_valid;
  logic                 r_frame_done;

  // Position of the pixel being accepted; start-of-frame forces it to the origin.
  assign w_col = in_sof ? '0 : r_col;
  assign w_row = in_sof ? '0 : r_row;

  assign w_last_pix = (w_row == R_LAST) && (w_col == C_LAST);

`ifdef CONV_WINDOW_STRIDE2_EN
  assign w_win_ok = (w_row >= R_FIRST) && (w_col >= C_FIRST) &&
                    (w_row[0] == R_FIRST[0]) && (w_col[0] == C_FIRST[0]);
`else
  assign w_win_ok = (w_row >= R_FIRST) && (w_col >= C_FIRST);
`endif

  // All line buffers advance together, so one shared pointer gives an IMG_W-deep delay each.
  always_comb begin
    for (int j = 0; j < NB; j++) begin
      w_lb_out[j] = r_lb[j][r_ptr];
    end
  end

  // Buffer j delays by (j+1) rows, so the top tap comes from the last buffer in the chain.
  always_comb begin
    for (int t = 0; t < KSIZE; t++) begin
      w_newcol[t] = in_pix;
    end
    for (int t = 0; t < NB; t++) begin
      w_newcol[t] = w_lb_out[NB-1-t];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb[0][r_ptr] <= in_pix;
      for (int j = 1; j < NB; j++) begin
        r_lb[j][r_ptr] <= w_lb_out[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_ptr        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= in_valid && w_win_ok;
      r_frame_done <= in_valid && w_last_pix;
      if (in_valid) begin
        r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
        if (w_col == C_LAST) begin
          r_col <= '0;
          r_row <= (w_row == R_LAST) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (in_valid) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          r_win[r*KSIZE+c] <= r_win[r*KSIZE+c+1];
        end
        r_win[r*KSIZE+KSIZE-1] <= w_newcol[r];
      end
    end
  end

  assign win        = r_win;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: per-cycle model of out_valid/frame_done/window plus frame-level counts.
module tb_conv_window_gen;
  localparam int W  = 32;
  localparam int K  = 5;
  localparam int IW = 28;
  localparam int IH = 28;
  localparam int WV = W*K*K;
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam int NWIN   = 144;
  localparam int SEC24  = 118;
  localparam int LAST0  = 638;
  localparam int LAST4  = 642;
  localparam int LAST24 = 754;
  localparam int LASTFD = 0;
`else
  localparam int NWIN   = 576;
  localparam int SEC24  = 117;
  localparam int LAST0  = 667;
  localparam int LAST4  = 671;
  localparam int LAST24 = 783;
  localparam int LASTFD = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_pix;
  logic          in_valid;
  logic          in_sof;
  logic [WV-1:0] win;
  logic          out_valid;
  logic          frame_done;

  int checks;
  int errors;
  int nwin, first_idx, first_w0, first_w12, first_w24, second_w24;
  int last_w0, last_w4, last_w24, last_fd;

  conv_window_gen #(.WORDWIDTH(W), .KSIZE(K), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof),
    .win(win), .out_valid(out_valid), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WV-1:0] exp_win(input int base, input int row, input int col);
    logic [WV-1:0] v;
    v = '0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        v[(rr*K+cc)*W +: W] = W'(base + (row-K+1+rr)*IW + (col-K+1+cc));
    return v;
  endfunction

  function automatic int word(input logic [WV-1:0] v, input int k);
    return int'(v[k*W +: W]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WV-1:0] obs, input logic [WV-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams npix raster pixels of value base+index; gap inserts an idle cycle (with a stray sof) after each.
  task automatic run_frame(input int base, input bit gap, input int npix, input bit sof);
    logic [WV-1:0] ew;
    int r, c;
    bit ev, efd;
    nwin = 0; first_idx = -1; first_w0 = -1; first_w12 = -1; first_w24 = -1;
    second_w24 = -1; last_w0 = -1; last_w4 = -1; last_w24 = -1; last_fd = -1;
    for (int i = 0; i < npix; i++) begin
      r = i / IW;
      c = i % IW;
      in_valid = 1'b1;
      in_sof   = sof && (i == 0);
      in_pix   = W'(base + i);
      tick();
      ev = (r >= K-1) && (c >= K-1);
`ifdef CONV_WINDOW_STRIDE2_EN
      ev = ev && ((r-K+1) % 2 == 0) && ((c-K+1) % 2 == 0);
`endif
      efd = (i == IW*IH-1);
      ew  = exp_win(base, r, c);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("frame_done", 32'(frame_done), 32'(efd));
      if (ev) begin
        chkw("window", win, ew);
        if (nwin == 0) begin
          first_idx = i; first_w0 = word(win, 0); first_w12 = word(win, 12); first_w24 = word(win, 24);
        end
        if (nwin == 1) second_w24 = word(win, 24);
        last_w0 = word(win, 0); last_w4 = word(win, 4); last_w24 = word(win, 24);
        last_fd = int'(frame_done);
        nwin++;
      end
      if (gap) begin
        in_valid = 1'b0;
        in_sof   = 1'b1;
        in_pix   = $urandom;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'd0);
        if (ev) chkw("idle_window_held", win, ew);
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chkw("rst_window", win, '0);
    rst_n = 1'b1;

    run_frame(0, 1'b0, IW*IH, 1'b1);
    chk("f1_nwin", nwin, NWIN);
    chk("f1_first_idx", first_idx, 116);
    chk("f1_first_w0", first_w0, 0);
    chk("f1_first_w12", first_w12, 58);
    chk("f1_first_w24", first_w24, 116);
    chk("f1_second_w24", second_w24, SEC24);
    chk("f1_last_w0", last_w0, LAST0);
    chk("f1_last_w4", last_w4, LAST4);
    chk("f1_last_w24", last_w24, LAST24);
    chk("f1_last_fd", last_fd, LASTFD);

    run_frame(1000, 1'b0, IW*IH, 1'b1);
    chk("f2_nwin", nwin, NWIN);
    chk("f2_first_w0", first_w0, 1000);
    chk("f2_first_w24", first_w24, 1116);

    run_frame(0, 1'b1, IW*IH, 1'b1);
    chk("gap_nwin", nwin, NWIN);
    chk("gap_first_w24", first_w24, 116);
    chk("gap_last_w24", last_w24, LAST24);

    run_frame(0, 1'b0, 300, 1'b1);
    run_frame(2000, 1'b0, IW*IH, 1'b1);
    chk("sof_first_idx", first_idx, 116);
    chk("sof_nwin", nwin, NWIN);
    chk("sof_first_w0", first_w0, 2000);

    run_frame(0, 1'b0, 200, 1'b1);
    rst_n = 1'b0; in_valid = 1'b1; in_pix = W'(200);
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chkw("midrst_window", win, '0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    run_frame(3000, 1'b0, IW*IH, 1'b0);
    chk("postrst_nwin", nwin, NWIN);
    chk("postrst_first_idx", first_idx, 116);
    chk("postrst_first_w0", first_w0, 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
